// File: rtl/adc_spi_responder.sv
// SPI responder that answers a master's start/SGL/ODD/MSBF command with a 12-bit sample.
// All SPI inputs are oversampled on clk; MISO is launched on detected SCK falls.
module adc_spi_responder #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        adc_clk,
    input  logic        adc_cs,
    input  logic        adc_mosi,
    output logic        adc_miso,
    input  logic [11:0] sample_ch0,
    input  logic [11:0] sample_ch1,
    output logic [2:0]  last_cmd,
    output logic [15:0] conv_count,
    output logic        frame_err,
    output logic        busy
);

    localparam int DATA_W = 12;

    typedef enum logic [2:0] {IDLE, CMD, NULL_BIT, DATA, DONE} state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sck_sync;
    logic [SYNC_STAGES-1:0]   cs_sync;
    logic [SYNC_STAGES-1:0]   mosi_sync;
    logic                     sck_hist;
    logic                     sck_s, cs_s, mosi_s;
    logic                     sck_rise, sck_fall;
    logic [1:0]               bit_cnt;
    logic                     cmd_sgl, cmd_odd, cmd_msbf;
    logic [3:0]               idx;
    logic                     b0_sent;
    logic                     lsb_dir;
    logic [DATA_W-1:0]        snapshot;
    logic                     load_snap;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist;
    assign sck_fall = ~sck_s & sck_hist;
    assign busy     = (state != IDLE);

    // The sample is frozen at the MSBF rise so a live-updating ADC cannot tear a word.
    assign load_snap = reset_n && !cs_s && (state == CMD) && sck_rise && (bit_cnt == 2'd2);

    always_ff @(posedge clk) begin
        if (load_snap) begin
            snapshot <= cmd_odd ? sample_ch1 : sample_ch0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_sync   <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            sck_hist   <= 1'b0;
            state      <= IDLE;
            adc_miso   <= IDLE_MISO;
            last_cmd   <= 3'b000;
            conv_count <= 16'h0000;
            frame_err  <= 1'b0;
            bit_cnt    <= 2'd0;
            cmd_sgl    <= 1'b0;
            cmd_odd    <= 1'b0;
            cmd_msbf   <= 1'b0;
            idx        <= 4'd0;
            b0_sent    <= 1'b0;
            lsb_dir    <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], adc_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], adc_mosi};
            sck_hist  <= sck_s;
            frame_err <= 1'b0;

            if (cs_s) begin
                state    <= IDLE;
                adc_miso <= IDLE_MISO;
                if (state == CMD || state == NULL_BIT || state == DATA) begin
                    frame_err <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (sck_rise && mosi_s) begin
                            state   <= CMD;
                            bit_cnt <= 2'd0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 2'd1;
                            case (bit_cnt)
                                2'd0:    cmd_sgl <= mosi_s;
                                2'd1:    cmd_odd <= mosi_s;
                                default: begin
                                    cmd_msbf <= mosi_s;
                                    last_cmd <= {cmd_sgl, cmd_odd, mosi_s};
                                    state    <= NULL_BIT;
                                end
                            endcase
                        end
                    end
                    NULL_BIT: begin
                        if (sck_fall) begin
                            adc_miso <= 1'b0;
                            idx      <= 4'd11;
                            b0_sent  <= 1'b0;
                            lsb_dir  <= 1'b0;
                            state    <= DATA;
                        end
                    end
                    DATA: begin
                        if (sck_fall) begin
                            if (!b0_sent) begin
                                adc_miso <= snapshot[idx];
                                if (idx == 4'd0) b0_sent <= 1'b1;
                                else             idx     <= idx - 4'd1;
                            end else if (!lsb_dir && !cmd_msbf) begin
                                // LSB-first repeat starts at B1; B0 is not resent.
                                adc_miso <= snapshot[1];
                                idx      <= 4'd2;
                                lsb_dir  <= 1'b1;
                            end else if (lsb_dir && idx != 4'd12) begin
                                adc_miso <= snapshot[idx];
                                idx      <= idx + 4'd1;
                            end else begin
                                adc_miso   <= 1'b0;
                                state      <= DONE;
                                conv_count <= conv_count + 16'd1;
                            end
                        end
                    end
                    DONE: begin
                        adc_miso <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of input synchroniser flops on adc_clk, adc_cs and adc_mosi (legal range 2..4).
REQ-002 Parameter IDLE_MISO, default 1'b1, is the adc_miso level driven while not selected.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port reset_n, input, 1 bit: the reset; it is synchronous and active-low.
REQ-005 Port adc_clk, input, 1 bit: SPI serial clock from the audio master, asynchronous to clk.
REQ-006 Port adc_cs, input, 1 bit: SPI chip select from the master, active-low.
REQ-007 Port adc_mosi, input, 1 bit: command bits from the master.
REQ-008 Port adc_miso, output, 1 bit: conversion result bits to the master.
REQ-009 Port sample_ch0, input, 12 bits: channel 0 value to report.
REQ-010 Port sample_ch1, input, 12 bits: channel 1 value to report.
REQ-011 Port last_cmd, output, 3 bits: {SGL, ODD, MSBF} of the most recently accepted command.
REQ-012 Port conv_count, output, 16 bits: count of completed frames.
REQ-013 Port frame_err, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 Each of adc_clk, adc_cs and adc_mosi shall pass through SYNC_STAGES flops, followed by one history flop on adc_clk for edge detection.
REQ-016 An SCK rise or fall event is a single-cycle comparison of the synchronised adc_clk against its history flop; the master guarantees each adc_clk phase is at least SYNC_STAGES+2 clk cycles long.
REQ-017 The state machine has five states: IDLE, CMD, NULL, DATA, DONE.
REQ-018 Synchronised adc_cs high, in any state, shall force IDLE on the next cycle and drive adc_miso to IDLE_MISO; this takes priority over a simultaneous SCK event.
REQ-019 If adc_cs rises while in CMD, NULL or DATA, frame_err shall pulse for exactly one cycle and conv_count shall be unchanged.
REQ-020 IDLE: with cs low, an SCK rise with mosi=1 (start bit) moves to CMD with bit counter 0; rises with mosi=0 are ignored (leading zeros).
REQ-021 CMD: the next three SCK rises capture SGL, ODD and MSBF in that order.
REQ-022 On the MSBF rise: snapshot ODD ? sample_ch1 : sample_ch0 into a 12-bit shift register, update last_cmd, and go to NULL.
REQ-023 NULL: the next SCK fall drives adc_miso=0 (null bit) and moves to DATA with index 11.
REQ-024 DATA, MSB-first phase: each SCK fall drives snapshot[index] and then decrements index, so B11..B0 go out on 12 falls.
REQ-025 If MSBF=1: the first SCK fall after B0 drives 0 and enters DONE.
REQ-026 If MSBF=0: after B0, subsequent falls drive B1..B11 (LSB-first repeat); the fall after B11 drives 0 and enters DONE.
REQ-027 conv_count shall increment by 1 on the cycle DONE is entered, wrapping 16'hFFFF to 16'h0000.
REQ-028 DONE: adc_miso is held at 0, extra SCK edges are ignored, and the block waits for cs high.
REQ-029 adc_miso shall change on the cycle following the detected SCK fall event; it shall never change on a rise event.
REQ-030 The snapshot shall not change during a frame, even if sample_ch0/1 change.

Reset
REQ-031 When reset_n is low at a clk edge, the block shall enter IDLE and clear all synchroniser and history flops to their idle levels (adc_clk 0, adc_cs 1, adc_mosi 0).
REQ-032 Output values while in reset: adc_miso=IDLE_MISO, last_cmd=0, conv_count=0, frame_err=0, busy=0.
REQ-033 Reset asserted mid-frame shall abort the frame without a frame_err pulse.

Verification
REQ-034 sample_ch0=12'hA5C, command bits 1,1,0,1 (start, SGL, ODD=0, MSBF=1) -> MISO bits on falls are 0, then 1010_0101_1100, then 0; conv_count 0->1; last_cmd=3'b101.
REQ-035 sample_ch1=12'h801, command with ODD=1 and MSBF=0 -> 0, 1000_0000_0001, then 0000_0000_001 (B1..B11), then 0; conv_count increments.
REQ-036 Three leading zero bits before the start bit -> frame decodes identically to REQ-034.
REQ-037 cs raised after 5 data bits -> one frame_err pulse, adc_miso=IDLE_MISO, conv_count unchanged; the next full frame succeeds.
REQ-038 sample_ch0 changed mid-frame -> the transmitted word equals the value at the MSBF rise.
REQ-039 conv_count preset to 16'hFFFF via 65535 frames (or forced) -> one more frame gives 16'h0000; reset_n low mid-frame -> busy=0 and adc_miso=1 next cycle, with no frame_err.
